matrix_scan_pio: RTL
====================

MATRIX_SCAN_PIO -- requirements
Module: matrix_scan_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning column bits per row and Avalon data width.
REQ-002 SHALL have parameter ROWS, default 16, meaning number of scanned rows (2..64).
REQ-003 SHALL have parameter PRESCALE, default 5000, meaning clk cycles each row is displayed (>=2).
REQ-004 SHALL have localparam AW = clog2(ROWS+2), meaning address width.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  AW  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  WIDTH  write data.
REQ-011 readdata  output  WIDTH  read data, combinational from address.
REQ-012 row_sel  output  ROWS  row drive, one-hot, registered.
REQ-013 col_data  output  WIDTH  column data for the active row, registered.

Function
REQ-014 Register map SHALL be: addr 0 CTRL (bit0 EN, bit1 ROW_INV, bit2 SWAP, rest read 0); addr 1 STATUS (current row index, zero-extended); addr 2..ROWS+1 row buffer entries 0..ROWS-1.
REQ-015 A write SHALL occur on a rising clk when chipselect=1 and write_n=0; writes to STATUS or addresses > ROWS+1 SHALL be ignored.
REQ-016 readdata SHALL return CTRL, STATUS or row entry for the decoded address, and 0 for unmapped addresses.
REQ-017 With EN=1 a prescaler SHALL count 0..PRESCALE-1; on terminal count it SHALL wrap to 0 and the row index SHALL advance by 1, wrapping ROWS-1 -> 0.
REQ-018 With EN=0 prescaler and row index SHALL be held at 0, and row_sel and col_data SHALL be 0 on the next cycle regardless of ROW_INV.
REQ-019 With EN=1, row_sel SHALL equal one-hot(row index), bitwise inverted when ROW_INV=1, and col_data SHALL equal the displayed-buffer entry of the row index, both one cycle after the index changes (latency 1).
REQ-020 EN rising 0->1 SHALL start scanning at row 0 with prescaler 0; row 0 SHALL be shown for exactly PRESCALE cycles.
REQ-021 A write to the row entry currently displayed SHALL appear on col_data one cycle after the write edge (no-double-buffer build).
REQ-022 A CTRL write SHALL take effect on the following cycle; simultaneous CTRL write and terminal count SHALL still advance the row unless EN is written 0.

Reset
REQ-023 reset=1 SHALL asynchronously clear CTRL, prescaler, row index, all buffer entries, row_sel and col_data to 0.
REQ-024 reset asserted mid-scan SHALL abort the scan; after release the block SHALL remain idle until EN is written 1.

Configuration
REQ-025 Macro MATRIX_SCAN_DOUBLE_BUF_EN SHALL select double buffering.
REQ-026 With the macro defined, row-entry writes SHALL go to a back buffer and reads SHALL return the back buffer; writing SWAP=1 SHALL latch a pending swap, exchanged with the front buffer at the next row-index wrap ROWS-1 -> 0 (or immediately when EN=0); SWAP SHALL read 1 while pending and self-clear at the exchange.
REQ-027 Without the macro, a single buffer SHALL be used, SWAP SHALL be ignored and read 0.

Structure
REQ-028 A shared package matrix_scan_pkg SHALL hold register address constants (ADDR_CTRL=0, ADDR_STATUS=1, ADDR_ROW0=2) and CTRL bit index constants.
REQ-029 One sub-module matrix_scan_timer SHALL implement prescaler and row index counter with inputs en, outputs row_idx and wrap pulse.

Verification (WIDTH=16, ROWS=4, PRESCALE=3)
REQ-030 Reset then read all addresses -> readdata 0 everywhere; row_sel=0, col_data=0.
REQ-031 Write rows 0x0001,0x0002,0x0004,0x0008, CTRL=0x1 -> row_sel 0001,0010,0100,1000 each 3 cycles with col_data 0x0001..0x0008, then wraps to 0001; STATUS tracks 0..3.
REQ-032 CTRL=0x3 while scanning -> row_sel 1110,1101,...; CTRL=0x0 -> row_sel=0, col_data=0, STATUS=0 next cycle.
REQ-033 Write 0xBEEF to displayed row's entry mid-period -> col_data=0xBEEF one cycle later; write to address 6 -> no state change, readdata 0.
REQ-034 Assert reset during row 2 -> outputs 0 immediately; after release CTRL reads 0 and no scan occurs.
REQ-035 MATRIX_SCAN_DOUBLE_BUF_EN build: write back row 0 = 0xAAAA, CTRL=0x5 during row 1 -> front unchanged until wrap, then col_data=0xAAAA in row 0 and SWAP reads 0.

Source files
------------

// File: rtl/matrix_scan_pkg.sv
// Shared register map and CTRL bit positions for the matrix scan PIO.
// Double buffering is enabled by defining MATRIX_SCAN_DOUBLE_BUF_EN.
package matrix_scan_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_ROW0   = 2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ROW_INV = 1;
  localparam int CTRL_SWAP    = 2;

endpackage

// File: rtl/matrix_scan_if.sv
// Avalon-MM slave bus bundle for the matrix scan PIO.
// The master modport drives the bus; the slave modport answers reads.
interface matrix_scan_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
);

  logic [AW-1:0]    address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/matrix_scan_timer.sv
// Row dwell prescaler and row index counter for the matrix scan PIO.
// Both counters sit at zero whenever en is low.
module matrix_scan_timer #(
  parameter int ROWS     = 16,
  parameter int PRESCALE = 5000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    wrap
);

  localparam int PW = $clog2(PRESCALE);
  localparam int RW = $clog2(ROWS);

  logic [PW-1:0] pre;
  logic          tc;

  assign tc   = en && (pre == PW'(PRESCALE - 1));
  assign wrap = tc && (row_idx == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre     <= '0;
      row_idx <= '0;
    end else if (!en) begin
      pre     <= '0;
      row_idx <= '0;
    end else if (tc) begin
      pre     <= '0;
      row_idx <= wrap ? '0 : row_idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan_pio.sv
// Avalon-MM row-scanned matrix driver: CTRL/STATUS plus a row buffer.
// Define MATRIX_SCAN_DOUBLE_BUF_EN for a back buffer swapped at frame wrap.
module matrix_scan_pio
  import matrix_scan_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int ROWS     = 16,
  parameter int PRESCALE = 5000
) (
  input  logic             clk,
  input  logic             reset,
  matrix_scan_if.slave     bus,
  output logic [ROWS-1:0]  row_sel,
  output logic [WIDTH-1:0] col_data
);

  localparam int AW = $clog2(ROWS + 2);
  localparam int RW = $clog2(ROWS);

  localparam logic [AW-1:0] A_CTRL   = AW'(ADDR_CTRL);
  localparam logic [AW-1:0] A_STATUS = AW'(ADDR_STATUS);
  localparam logic [AW-1:0] A_ROW0   = AW'(ADDR_ROW0);
  localparam logic [AW-1:0] A_LAST   = AW'(ROWS + 1);

  logic             en;
  logic             inv;
  logic             swap_pend;
  logic [RW-1:0]    row_idx;
  logic             wrap;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_row;
  logic             row_hit;
  logic [RW-1:0]    ent;
  logic [ROWS-1:0]  onehot;
  logic [WIDTH-1:0] rd_entry;
  logic [WIDTH-1:0] front [ROWS];

  assign wr      = bus.chipselect & ~bus.write_n;
  assign row_hit = (bus.address >= A_ROW0) && (bus.address <= A_LAST);
  assign ent     = RW'(bus.address - A_ROW0);
  assign wr_ctrl = wr && (bus.address == A_CTRL);
  assign wr_row  = wr && row_hit;
  assign onehot  = ROWS'(1) << row_idx;

  matrix_scan_timer #(
    .ROWS     (ROWS),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .row_idx (row_idx),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en  <= 1'b0;
      inv <= 1'b0;
    end else if (wr_ctrl) begin
      en  <= bus.writedata[CTRL_EN];
      inv <= bus.writedata[CTRL_ROW_INV];
    end
  end

`ifdef MATRIX_SCAN_DOUBLE_BUF_EN
  logic [WIDTH-1:0] back [ROWS];
  logic             do_swap;

  // An idle scanner has no frame boundary to wait for.
  assign do_swap  = swap_pend && (wrap || !en);
  assign rd_entry = back[ent];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_pend <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
    end else begin
      if (do_swap) begin
        swap_pend <= 1'b0;
        for (int i = 0; i < ROWS; i++) begin
          front[i] <= back[i];
          back[i]  <= front[i];
        end
      end
      if (wr_row)
        back[ent] <= bus.writedata;
      if (wr_ctrl && bus.writedata[CTRL_SWAP])
        swap_pend <= 1'b1;
    end
  end
`else
  logic unused_wrap;

  assign unused_wrap = wrap;
  assign swap_pend   = 1'b0;
  assign rd_entry    = front[ent];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++)
        front[i] <= '0;
    end else if (wr_row) begin
      front[ent] <= bus.writedata;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sel  <= '0;
      col_data <= '0;
    end else if (!en) begin
      row_sel  <= '0;
      col_data <= '0;
    end else begin
      row_sel  <= onehot ^ {ROWS{inv}};
      col_data <= front[row_idx];
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (1'b1)
      bus.address == A_CTRL: begin
        bus.readdata[CTRL_EN]      = en;
        bus.readdata[CTRL_ROW_INV] = inv;
        bus.readdata[CTRL_SWAP]    = swap_pend;
      end
      bus.address == A_STATUS:
        bus.readdata = WIDTH'(row_idx);
      row_hit:
        bus.readdata = rd_entry;
      default: ;
    endcase
  end

endmodule
